// File: rtl/ff_tx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ff_tx_pkg : shared types and helpers for the ff_serial_tx transmitter
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
package ff_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Widest word the parity helper folds; wider words would be truncated.
  localparam int unsigned PAR_MAX_W = 64;

  // Line bits per frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned width,
                                             input int unsigned parity_en);
    return 32'd2 + width + ((parity_en != 0) ? 32'd1 : 32'd0);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] bits);
    return ^bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ff_bit_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ff_bit_timer : counts 0..CLKS_PER_BIT-1 while enabled, strobes on the wrap
// Revision     : 1.0 - initial release
// ----------------------------------------------------------------------------
module ff_bit_timer
  import ff_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int unsigned        CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = en_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/ff_serial_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ff_serial_tx : framed LSB-first serial transmitter (start/data/parity/stop)
// Revision     : 1.0 - initial release
// ----------------------------------------------------------------------------
module ff_serial_tx
  import ff_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic             abort_i,
  output logic             tx_out_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned      IDX_W    = cnt_width(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             par_q, par_d;
  logic             tx_out_q, tx_out_d;
  logic             done_q, done_d;
  logic             bit_end;
  logic             accept;

  // Ready in the last STOP cycle lets the next frame start with no idle gap.
  assign tx_ready_o = ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end))
                      && !abort_i && !rst;
  assign busy_o     = (state_q != ST_IDLE);
  assign accept     = tx_valid_i && tx_ready_o;

  ff_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q != ST_IDLE),
    .clr_i     (accept || abort_i),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      par_q    <= 1'b0;
      tx_out_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      tx_out_q <= tx_out_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    unique case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (bit_end) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Accept only happens in IDLE or the last STOP cycle; both lead to START.
    if (accept) begin
      state_d = ST_START;
      shift_d = tx_data_i;
      idx_d   = '0;
      par_d   = even_parity(PAR_MAX_W'(tx_data_i));
    end
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    done_d   = (state_q == ST_STOP) && bit_end && !abort_i;
    tx_out_d = 1'b1;
    case (state_d)
      ST_START:  tx_out_d = 1'b0;
      ST_DATA:   tx_out_d = shift_d[0];
      ST_PARITY: tx_out_d = par_d;
      default:   tx_out_d = 1'b1;
    endcase
  end

  assign tx_out_o = tx_out_q;
  assign done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ff_serial_tx.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ff_serial_tx: framed traffic on a scoreboard, checked against a cycle-level line model.
module tb_ff_serial_tx;

  localparam int W  = 3;
  localparam int C  = 4;
  localparam int P  = 1;
  localparam int N  = (2 + W + P) * C;
  localparam int C2 = 1;
  localparam int P2 = 0;
  localparam int N2 = (2 + W + P2) * C2;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic [W-1:0] tx_data  = '0;
  logic         tx_valid = 1'b0;
  logic         abort_s  = 1'b0;
  logic         tx_ready, tx_out, busy, done;

  logic [W-1:0] tx_data2  = '0;
  logic         tx_valid2 = 1'b0;
  logic         abort2    = 1'b0;
  logic         tx_ready2, tx_out2, busy2, done2;

  ff_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(P)) dut (
    .clk(clk), .rst(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .abort_i(abort_s), .tx_out_o(tx_out),
    .busy_o(busy), .done_o(done)
  );

  ff_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(C2), .PARITY_EN(P2)) dut2 (
    .clk(clk), .rst(rst), .tx_data_i(tx_data2), .tx_valid_i(tx_valid2),
    .tx_ready_o(tx_ready2), .abort_i(abort2), .tx_out_o(tx_out2),
    .busy_o(busy2), .done_o(done2)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] data;
    int           start;
  } frame_t;

  frame_t exp_q[$];
  int     n_checks   = 0;
  int     n_fail     = 0;
  int     kill_edge  = -1;
  int     last_start = 0;
  bit     mon_en     = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, required %b", name, ecnt, act, exp);
    end
  endtask

  // Line value at a given cycle offset into a frame, straight from the framing rules.
  function automatic logic line_bit(input logic [W-1:0] d, input int off,
                                    input int cpb, input int par);
    int b;
    b = off / cpb;
    if (b == 0) return 1'b0;
    if (b <= W) return d[b-1];
    if (par != 0 && b == W + 1) return ^d;
    return 1'b1;
  endfunction

  // Monitor: compares the main DUT against the model every cycle.
  frame_t mon_cur;
  bit     mon_active = 1'b0;
  int     done_at    = -1;

  initial begin : monitor
    int   c;
    int   off;
    logic e_out, e_busy, e_rdy;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        c = ecnt;
        if (mon_active && c >= mon_cur.start + N) mon_active = 1'b0;
        if (mon_active && kill_edge >= mon_cur.start && kill_edge <= c) mon_active = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].start < c) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_start: frame due at cycle %0d not tracked, now %0d", exp_q[0].start, c);
          void'(exp_q.pop_front());
        end
        if (!mon_active && exp_q.size() > 0 && exp_q[0].start == c) begin
          mon_cur    = exp_q.pop_front();
          mon_active = 1'b1;
        end
        if (mon_active) begin
          off    = c - mon_cur.start;
          e_out  = line_bit(mon_cur.data, off, C, P);
          e_busy = 1'b1;
          e_rdy  = (off == N - 1);
        end else begin
          off    = -1;
          e_out  = 1'b1;
          e_busy = 1'b0;
          e_rdy  = 1'b1;
        end
        e_rdy = e_rdy && !abort_s && !rst;
        check("tx_out", tx_out, e_out);
        check("busy", busy, e_busy);
        check("tx_ready", tx_ready, e_rdy);
        check("done", done, (done_at == c));
        if (mon_active && off == N - 1) done_at = c + 1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = W'($urandom);
    end
  endtask

  // Leaves tx_valid high after the accepting edge so a following send is back-to-back.
  task automatic send(input logic [W-1:0] d);
    int tries;
    bit got;
    int c;
    tries = 0;
    got   = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (!got && tries < 200) begin
      #1;
      c = ecnt;
      if (tx_ready === 1'b1) begin
        @(posedge clk);
        exp_q.push_back('{data: d, start: c + 1});
        last_start = c + 1;
        got        = 1'b1;
      end else begin
        @(negedge clk);
        tries++;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: tx_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  // Abort sampled on edge a.
  task automatic pulse_abort(input int a);
    do begin
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = W'($urandom);
    end while (ecnt < a - 1);
    abort_s   = 1'b1;
    kill_edge = a;
    @(negedge clk);
    abort_s = 1'b0;
  endtask

  // Reset sampled on edges a and a+1, with tx_valid offered throughout.
  task automatic pulse_rst(input int a);
    do begin
      @(negedge clk);
      tx_valid = 1'b0;
    end while (ecnt < a - 1);
    rst       = 1'b1;
    tx_valid  = 1'b1;
    tx_data   = W'($urandom);
    kill_edge = a;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    tx_valid = 1'b0;
  endtask

  // Directed frame on the CLKS_PER_BIT=1, no-parity instance.
  task automatic run2(input logic [W-1:0] d);
    @(negedge clk);
    tx_valid2 = 1'b1;
    tx_data2  = d;
    #1;
    check("dut2_ready_idle", tx_ready2, 1'b1);
    @(negedge clk);
    tx_valid2 = 1'b0;
    tx_data2  = ~d;
    for (int off = 0; off <= N2; off++) begin
      #3;
      check("dut2_tx_out", tx_out2, (off < N2) ? line_bit(d, off, C2, P2) : 1'b1);
      check("dut2_busy", busy2, (off < N2));
      check("dut2_done", done2, (off == N2));
      if (off == N2 - 1) check("dut2_ready_stop", tx_ready2, 1'b1);
      @(negedge clk);
    end
  endtask

  initial begin : stim
    int act;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    idle(50);
    send(3'd5);
    idle(N + 3);
    send(3'd6);
    send(3'd7);
    idle(N + 3);
    send(3'd5);
    pulse_abort(last_start + 10);
    idle(3);
    send(3'd4);
    idle(N + 3);
    send(3'd7);
    pulse_rst(last_start + 6);
    idle(3);

    // abort and tx_valid together while idle: no accept may happen
    @(negedge clk);
    abort_s  = 1'b1;
    tx_valid = 1'b1;
    tx_data  = W'($urandom);
    @(negedge clk);
    abort_s  = 1'b0;
    tx_valid = 1'b0;
    idle(2);

    for (int it = 0; it < 24; it++) begin
      act = $urandom_range(0, 5);
      send(W'($urandom));
      if (act == 0) pulse_abort(last_start + $urandom_range(1, N - 1));
      else if (act == 1) pulse_rst(last_start + $urandom_range(1, N - 1));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, N + 4));
    end
    idle(N + 4);

    run2(3'd4);
    idle(2);
    for (int it = 0; it < 3; it++) begin
      run2(W'($urandom));
      idle(1);
    end

    n_checks++;
    if (exp_q.size() != 0 || mon_active) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d frames pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ff_serial_tx.md
Name: ff_serial_tx

Overview:
Parallel-to-serial transmitter for small register words. It is the driving end of the serial link whose receiving side captures bits into a flip-flop bank. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first as a framed line: start bit, data bits, optional even parity, then stop bit. It sits between register/control logic and a single-wire output.

Parameters:
WIDTH, 3, data word width in bits (≥1)
CLKS_PER_BIT, 4, clk cycles each line bit is held (≥1; 1 must work)
PARITY_EN, 1, 1 = append even-parity bit after data, 0 = no parity bit

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
tx_data  input  WIDTH  word to send, sampled only on accept
tx_valid  input  1  source has a word
tx_ready  output  1  block can accept; transfer occurs on the edge where tx_valid && tx_ready
abort  input  1  synchronous frame cancel
tx_out  output  1  serial line, idle high, registered
busy  output  1  high while a frame is on the line
done  output  1  one-cycle pulse after a frame completes normally

Behaviour:
- Interface (decided): one clock, clk; synchronous active-high reset, rst.
- Reset values: tx_out=1, tx_ready=1, busy=0, done=0, state IDLE, counters 0.
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_EN=0.
- Accept on edge k latches tx_data into the shift register. tx_out is valid from cycle k+1. Later changes on tx_data are ignored.
- Each line bit is held exactly CLKS_PER_BIT cycles, timed by a bit counter that wraps at CLKS_PER_BIT-1.
- Bit values: START drives 0. DATA drives bits LSB-first, WIDTH bits. PARITY drives the XOR of the latched bits. STOP drives 1.
- Frame length: N = (2 + WIDTH + PARITY_EN) × CLKS_PER_BIT cycles.
- tx_ready is high in IDLE, and also in the final cycle of STOP. This allows back-to-back frames with no idle gap.
- tx_ready is forced 0 while abort=1 or rst=1.
- busy is high in every non-IDLE state.
- done is registered: high for one cycle, the cycle after the last STOP cycle (cycle k+N+1).
  - If a new word is accepted in the last STOP cycle, done and the new START bit coincide.
- Transitions: START→DATA→(PARITY)→STOP, each on bit-counter wrap. DATA shifts on each wrap and uses a data-bit index to leave after WIDTH bits. STOP→IDLE, or STOP→START on a back-to-back accept.
- abort in any non-IDLE state: next cycle state=IDLE, tx_out=1, busy=0, tx_ready=1, no done pulse. abort in IDLE has no effect.
- abort and tx_valid in the same cycle: abort wins and no accept happens.
- rst mid-frame: same outputs as reset on the next cycle. Any pending done is dropped.
- Counter widths: $clog2 of the range, minimum 1 bit, no overflow for any legal parameter.

Decomposition:
- Package ff_tx_pkg:
  - state enum typedef tx_state_t
  - constant FRAME_BITS (as a function of WIDTH and PARITY_EN)
  - function even_parity()
- Sub-module ff_bit_timer: counts 0..CLKS_PER_BIT-1 while enabled, outputs a bit_end strobe on wrap, sync clear. Top level holds the FSM, shift register and output registers.

Test Plan:
1. Defaults. Send 5 (101), accept at edge 0. Required tx_out:
   - cycles 1–4 = 0, 5–8 = 1, 9–12 = 0, 13–16 = 1
   - parity 17–20 = 0, stop 21–24 = 1
   - done=1 only at cycle 25; tx_ready=1 at 24.
2. Back-to-back. Send 6 then 7, tx_valid held high. Required:
   - frame 1 bits 0,1,1, parity 0
   - frame 2 START begins cycle 25, coincident with done; bits 1,1,1, parity 1
   - no idle-high gap between frames.
3. Abort. Send 5, assert abort at cycle 10. Required: cycle 11 tx_out=1, busy=0, tx_ready=1; no done. A fresh send of 4 then frames correctly.
4. Reset mid-frame. Send 7, assert rst at cycle 6. Required: cycle 7 tx_out=1, tx_ready=1, busy=0, done=0. tx_valid during rst is not accepted.
5. PARITY_EN=0, CLKS_PER_BIT=1. Send 4 (100). Required tx_out cycles 1–5 = 0,0,0,1,1; done at cycle 6.
6. Hold: tx_valid low for 50 cycles after reset. Required: tx_out stays 1, busy 0, done never pulses. Changing tx_data mid-frame does not alter transmitted bits.
